// File: rtl/riscv_v_pipe_ctrl_pkg.sv
// riscv_v_pipe_ctrl_pkg: shared FSM states, stall counter width and popcount helper
package riscv_v_pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_e;
  localparam int STALL_W = 16;
  function automatic logic [4:0] popcnt(input logic [15:0] v);
    popcnt = '0;
    for (int i = 0; i < 16; i++) popcnt = popcnt + 5'(v[i]);
  endfunction
endpackage

// File: rtl/riscv_v_pipe_ctrl.sv
// riscv_v_pipe_ctrl: bubble-collapsing valid/enable sequencer with flush and drain control
module riscv_v_pipe_ctrl
  import riscv_v_pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  input  logic                  flush_req,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  stage_flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [4:0]            occupancy,
  output logic [STALL_W-1:0]    stall_cnt
);
  localparam int N = NUM_STAGES;
  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [N-1:0]       valid_q, valid_d;
  logic [N:0]         shift;
  logic [4:0]         occ_q;
  logic [STALL_W-1:0] stall_q;
  logic               all_v;
  // a stage may advance unless it and every stage downstream of it is full and blocked
  always_comb begin
    all_v = 1'b1;
    stage_en = '0;
    for (int i = N - 1; i >= 0; i--) begin
      all_v = all_v & valid_q[i];
      stage_en[i] = out_ready | ~all_v;
    end
  end
  assign in_ready    = stage_en[0] & (state_q == RUN) & ~flush_req & ~rst;
  assign out_valid   = valid_q[N-1] & ~flush_req;
  assign stage_flush = flush_req & ~rst;
  assign drain_done  = (state_q == DRAIN) & ~|valid_q & ~flush_req & ~rst;
  assign shift       = {valid_q, in_valid & in_ready};
  assign valid_d     = (rst | flush_req) ? '0 : (stage_en & shift[N-1:0]) | (~stage_en & valid_q);
  assign stage_valid = valid_q;
  assign occupancy   = occ_q;
  assign stall_cnt   = stall_q;
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    occ_q   <= popcnt(16'(valid_d));
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid & ~out_ready & ~&stall_q) stall_q <= stall_q + 1'b1;
      if (flush_req) begin
        state_q <= FLUSH;
        cnt_q   <= 4'(FLUSH_CYCLES);
      end else if (state_q == FLUSH) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_q <= RUN;
      end else if (state_q == DRAIN) begin
        if (~|valid_q) state_q <= RUN;
      end else if (drain_req) begin
        state_q <= DRAIN;
      end
    end
  end
endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// tb_riscv_v_pipe_ctrl: directed checks of streaming, back-pressure, flush, drain and reset
module tb_riscv_v_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_ready, out_valid;
  logic        flush_req, drain_req, drain_done, stage_flush;
  logic [2:0]  stage_en, stage_valid;
  logic [4:0]  occupancy;
  logic [15:0] stall_cnt;
  int          checks = 0;
  int          errors = 0;
  int          first, xfers, pulses;

  riscv_v_pipe_ctrl #(.NUM_STAGES(3), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .flush_req(flush_req),
    .drain_req(drain_req), .drain_done(drain_done), .stage_en(stage_en),
    .stage_flush(stage_flush), .stage_valid(stage_valid),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; flush_req = 1; drain_req = 1;
    tick(); tick();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stage_flush", stage_flush, 0);
    tick();
    rst = 0; flush_req = 0; drain_req = 0;
    #1;
    chk("reset_valid", stage_valid, 0);
    chk("reset_occ", occupancy, 0);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_drain_done", drain_done, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_stage_en", stage_en, 3'b111);

    in_valid = 1; out_ready = 1; first = -1; xfers = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (out_valid && first < 0) first = k;
      if (out_valid && out_ready) xfers++;
      tick();
    end
    chk("stream_first", first, 3);
    chk("stream_xfers", xfers, 7);
    chk("stream_stall", stall_cnt, 0);
    in_valid = 0;
    tick(); tick(); tick();
    chk("stream_empty", occupancy, 0);

    in_valid = 1; out_ready = 1;
    tick(); tick(); tick();
    out_ready = 0;
    #1;
    chk("bp_stage_en", stage_en, 3'b000);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_occ", occupancy, 3);
    repeat (5) tick();
    chk("bp_stall", stall_cnt, 5);
    chk("bp_valid", stage_valid, 3'b111);
    out_ready = 1; in_valid = 0;
    tick(); tick(); tick();
    chk("bp_drained", occupancy, 0);

    out_ready = 0; in_valid = 1; tick();
    in_valid = 0; tick();
    in_valid = 1; tick();
    in_valid = 0;
    #1;
    chk("bubble_valid", stage_valid, 3'b101);
    chk("bubble_stage_en", stage_en, 3'b011);
    chk("bubble_occ", occupancy, 2);
    tick();
    chk("bubble_collapse", stage_valid, 3'b110);
    chk("bubble_stall", stall_cnt, 6);
    in_valid = 1;
    tick();
    chk("fill_occ", occupancy, 3);
    chk("fill_stall", stall_cnt, 7);

    flush_req = 1;
    #1;
    chk("flush_stage_flush", stage_flush, 1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush_req = 0;
    #1;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", stage_valid, 0);
    chk("flush_hold1", in_ready, 0);
    tick();
    chk("flush_hold2", in_ready, 0);
    tick();
    chk("flush_release", in_ready, 1);
    chk("flush_stall", stall_cnt, 7);

    tick(); tick();
    chk("drain_pre_occ", occupancy, 2);
    in_valid = 0; out_ready = 1; drain_req = 1;
    tick();
    drain_req = 0; in_valid = 1;
    #1;
    chk("drain_in_ready", in_ready, 0);
    chk("drain_busy", drain_done, 0);
    tick();
    chk("drain_busy2", drain_done, 0);
    tick();
    chk("drain_done_pulse", drain_done, 1);
    chk("drain_done_occ", occupancy, 0);
    in_valid = 0;
    tick();
    chk("drain_done_once", drain_done, 0);
    chk("drain_run", in_ready, 1);

    drain_req = 1;
    #1;
    chk("drain_empty_early", drain_done, 0);
    tick();
    drain_req = 0;
    #1;
    chk("drain_empty_pulse", drain_done, 1);
    tick();
    chk("drain_empty_once", drain_done, 0);
    chk("drain_empty_run", in_ready, 1);

    in_valid = 1; out_ready = 0;
    tick(); tick();
    in_valid = 0; drain_req = 1;
    tick();
    drain_req = 0; flush_req = 1;
    #1;
    chk("dflush_valid", stage_valid, 3'b110);
    chk("dflush_in_ready", in_ready, 0);
    tick();
    flush_req = 0; pulses = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (drain_done) pulses++;
      tick();
    end
    chk("dflush_no_done", pulses, 0);
    chk("dflush_run", in_ready, 1);
    chk("dflush_stall", stall_cnt, 7);

    in_valid = 1; out_ready = 0;
    tick(); tick(); tick();
    chk("mid_occ", occupancy, 3);
    chk("mid_stall", stall_cnt, 7);
    rst = 1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_valid", stage_valid, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_drain_done", drain_done, 0);
    rst = 0; in_valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_v_pipe_ctrl.md
RISCV_V_PIPE_CTRL -- requirements
Module: riscv_v_pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of pipeline stage registers sequenced (legal 1..16).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, number of cycles input is held off after a flush (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream offers an element to stage 1.
REQ-006 SHALL have port in_ready  output  1  stage 1 accepts the offered element this cycle.
REQ-007 SHALL have port out_ready  input  1  downstream accepts the element in stage NUM_STAGES.
REQ-008 SHALL have port out_valid  output  1  stage NUM_STAGES holds a valid element.
REQ-009 SHALL have port flush_req  input  1  kill all in-flight elements.
REQ-010 SHALL have port drain_req  input  1  stop intake and empty the pipeline.
REQ-011 SHALL have port drain_done  output  1  one-cycle pulse: drain completed.
REQ-012 SHALL have port stage_en  output  NUM_STAGES  bit i-1 = enable for stage i register.
REQ-013 SHALL have port stage_flush  output  1  common flush for all stage registers.
REQ-014 SHALL have port stage_valid  output  NUM_STAGES  bit i-1 = stage i holds a valid element.
REQ-015 SHALL have port occupancy  output  5  count of set stage_valid bits.
REQ-016 SHALL have port stall_cnt  output  16  cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL compute stage_en combinationally, bubble-collapsing: en[N] = out_ready | ~valid[N]; en[i] = en[i+1] | ~valid[i] for i<N.
REQ-018 SHALL drive in_ready = en[1] & (state==RUN) & ~flush_req.
REQ-019 SHALL update, when en[i]=1, valid[i] <= valid[i-1] for i>1 and valid[1] <= in_valid & in_ready; valid[i] holds when en[i]=0.
REQ-020 SHALL drive out_valid = valid[N] & ~flush_req; a transfer occurs when out_valid & out_ready.
REQ-021 SHALL implement FSM states RUN, DRAIN, FLUSH.
REQ-022 SHALL, in any state, on flush_req=1: assert stage_flush combinationally that cycle, clear all valid bits at the next edge, enter FLUSH with hold-off counter = FLUSH_CYCLES; flush_req has priority over drain_req and over all enables.
REQ-023 SHALL remain in FLUSH (in_ready=0) until the counter decrements to 0, then return to RUN; flush_req during FLUSH reloads the counter.
REQ-024 SHALL, in RUN with drain_req=1 and flush_req=0, enter DRAIN; in DRAIN in_ready=0 while stages keep advancing.
REQ-025 SHALL, in DRAIN when all valid bits are 0, pulse drain_done for exactly one cycle and return to RUN the following cycle; drain_req while pipeline is already empty yields drain_done on the next cycle.
REQ-026 SHALL abort a drain without drain_done if flush_req arrives in DRAIN; drain_req in FLUSH or DRAIN is ignored.
REQ-027 SHALL compute occupancy as registered popcount of the next valid vector (matches stage_valid each cycle).
REQ-028 SHALL increment stall_cnt by 1 in cycles with out_valid=1 and out_ready=0, saturating at 16'hFFFF.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state=RUN, all valid bits 0, flush counter 0, stall_cnt 0, occupancy 0, drain_done 0; rst has priority over flush_req and drain_req.
REQ-030 SHALL, while rst=1, drive in_ready=0 and stage_flush=0.

Structure
REQ-031 SHALL place the FSM state enum (RUN, DRAIN, FLUSH) and the stall_cnt width constant in shared package riscv_v_pipe_ctrl_pkg.
REQ-032 SHALL be a single module with no sub-module; valid bits held in a local NUM_STAGES-wide register.

Verification (NUM_STAGES=3, FLUSH_CYCLES=2)
REQ-033 SHALL cover streaming: in_valid=1, out_ready=1 for 10 cycles -> first out_valid 3 cycles after first accept, then 1 per cycle, stall_cnt=0.
REQ-034 SHALL cover back-pressure: fill 3, out_ready=0 for 5 cycles -> in_ready=0, stage_en=3'b000, occupancy=3, stall_cnt=5; bubble collapse: valid=3'b101 with out_ready=0 -> stage_en=3'b011.
REQ-035 SHALL cover flush: occupancy=3, pulse flush_req -> stage_flush=1 that cycle, out_valid=0, occupancy=0 next cycle, in_ready=0 for 2 cycles, then 1.
REQ-036 SHALL cover drain: occupancy=2, drain_req, out_ready=1 -> in_ready=0, drain_done pulses once when occupancy=0, RUN restored; drain_req with empty pipe -> drain_done next cycle.
REQ-037 SHALL cover flush during drain and reset mid-stream: flush in DRAIN -> no drain_done; rst with occupancy=3, stall_cnt=7 -> all outputs 0 next cycle.
